// File: rtl/led_fader.sv
// Two-channel LED fader: level edges become PWM brightness ramps.
// Optional LED_FADER_GAMMA_EN squares brightness into the PWM duty.
module led_fader #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                l1,
  input  logic                l2,
  output logic                led1,
  output logic                led2,
  output logic                busy1,
  output logic                busy2,
  output logic [PWM_BITS-1:0] bri1,
  output logic [PWM_BITS-1:0] bri2
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PW-1:0] PLAST = PW'(STEP_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PW-1:0]       presc;
  logic                l1_q;
  logic                l2_q;
  logic                step_tick;
  logic [PWM_BITS-1:0] bri1_n;
  logic [PWM_BITS-1:0] bri2_n;

  function automatic logic [PWM_BITS-1:0] ramp(
    input logic [PWM_BITS-1:0] b,
    input logic                lq,
    input logic                tick
  );
    ramp = b;
    if (tick) begin
      if (lq && (b != MAX))
        ramp = b + 1'b1;
      else if (!lq && (b != '0))
        ramp = b - 1'b1;
    end
  endfunction

  function automatic logic moving(
    input logic [PWM_BITS-1:0] b,
    input logic                lq
  );
    moving = lq ? (b != MAX) : (b != '0);
  endfunction

  function automatic logic [PWM_BITS-1:0] duty(
    input logic [PWM_BITS-1:0] b
  );
`ifdef LED_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, b} * {{PWM_BITS{1'b0}}, b};
    duty = sq[2*PWM_BITS-1:PWM_BITS];
`else
    duty = b;
`endif
  endfunction

  // Full-on override keeps MAX solid across the counter wrap.
  function automatic logic pwm(
    input logic [PWM_BITS-1:0] b,
    input logic [PWM_BITS-1:0] cnt
  );
    pwm = (b == MAX) | (duty(b) > cnt);
  endfunction

  always_comb begin
    step_tick = (presc == PLAST);
    bri1_n    = ramp(bri1, l1_q, step_tick);
    bri2_n    = ramp(bri2, l2_q, step_tick);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      presc   <= '0;
      l1_q    <= 1'b0;
      l2_q    <= 1'b0;
      bri1    <= '0;
      bri2    <= '0;
      led1    <= 1'b0;
      led2    <= 1'b0;
      busy1   <= 1'b0;
      busy2   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      presc   <= step_tick ? '0 : presc + 1'b1;
      l1_q    <= l1;
      l2_q    <= l2;
      bri1    <= bri1_n;
      bri2    <= bri2_n;
      busy1   <= moving(bri1, l1_q);
      busy2   <= moving(bri2, l2_q);
      led1    <= pwm(bri1, pwm_cnt);
      led2    <= pwm(bri2, pwm_cnt);
    end
  end

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader: ramps, duty, reversal, independence.
// Two instances: fast (STEP_DIV=2) and slow (STEP_DIV=64), PWM_BITS=4.
module tb_led_fader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic f_rst, f_l1, f_l2;
  logic f_led1, f_led2, f_busy1, f_busy2;
  logic [3:0] f_bri1, f_bri2;
  logic s_rst, s_l1, s_l2;
  logic s_led1, s_led2, s_busy1, s_busy2;
  logic [3:0] s_bri1, s_bri2;

  led_fader #(.PWM_BITS(4), .STEP_DIV(2)) u_fast (
    .clk(clk), .rst(f_rst), .l1(f_l1), .l2(f_l2),
    .led1(f_led1), .led2(f_led2),
    .busy1(f_busy1), .busy2(f_busy2),
    .bri1(f_bri1), .bri2(f_bri2)
  );

  led_fader #(.PWM_BITS(4), .STEP_DIV(64)) u_slow (
    .clk(clk), .rst(s_rst), .l1(s_l1), .l2(s_l2),
    .led1(s_led1), .led2(s_led2),
    .busy1(s_busy1), .busy2(s_busy2),
    .bri1(s_bri1), .bri2(s_bri2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic count_s_led(output int hi);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (s_led1) hi++;
    end
  endtask

  int prev, hi, budget, exp_g8, exp_g9;
  bit ok;

  initial begin
    f_rst = 1'b1; f_l1 = 1'b1; f_l2 = 1'b1;
    s_rst = 1'b1; s_l1 = 1'b0; s_l2 = 1'b0;
    @(negedge clk);

    // reset held three cycles with inputs high
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_led", {f_led1, f_led2}, 0);
      check("rst_busy", {f_busy1, f_busy2}, 0);
      check("rst_bri", {f_bri1, f_bri2}, 0);
    end

    // ramp up: ticks on odd cycles after release
    f_rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      check("ramp_bri1", f_bri1, (k + 1) / 2);
      check("ramp_bri2", f_bri2, (k + 1) / 2);
      if (k == 1) check("ramp_busy", f_busy1, 1);
    end
    step();
    check("on_busy", f_busy1, 0);
    hi = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (f_led1 && !f_busy1 && f_bri1 == 4'd15) hi++;
    end
    check("on_led_const", hi, 64);

    // reversal at bri1 == 6
    f_rst = 1'b1; f_l1 = 1'b1; f_l2 = 1'b0;
    step(); step();
    f_rst = 1'b0;
    budget = 40;
    while (f_bri1 != 4'd6 && budget > 0) begin
      step();
      budget--;
    end
    check("rev_reach6", f_bri1, 6);
    f_l1 = 1'b0;
    prev = 6;
    budget = 40;
    while (f_bri1 != 4'd0 && budget > 0) begin
      step();
      budget--;
      ok = (f_bri1 == prev) || (f_bri1 == prev - 1);
      check("rev_step", ok, 1);
      check("rev_ch2", {f_bri2, f_led2}, 0);
      prev = f_bri1;
    end
    check("rev_zero", f_bri1, 0);
    step();
    check("rev_busy", f_busy1, 0);
    hi = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (f_led1) hi++;
    end
    check("off_led_const", hi, 0);

    // independence: l2 toggles every 10 cycles, l1 low
    f_rst = 1'b1; f_l1 = 1'b0; f_l2 = 1'b0;
    step(); step();
    f_rst = 1'b0;
    prev = 0;
    for (int k = 0; k < 80; k++) begin
      step();
      check("ind_ch1", {f_led1, f_busy1}, 0);
      if ((k % 2) == 0) check("ind_notick", f_bri2, prev);
      ok = (f_bri2 == prev) || (f_bri2 == prev + 1) || (f_bri2 == prev - 1);
      check("ind_delta", ok, 1);
      prev = f_bri2;
      if ((k % 10) == 9) f_l2 = ~f_l2;
    end

    // duty on the slow instance
`ifdef LED_FADER_GAMMA_EN
    exp_g8 = 4; exp_g9 = 5;
`else
    exp_g8 = 8; exp_g9 = 9;
`endif
    s_l1 = 1'b1;
    step();
    s_rst = 1'b0;
    budget = 2000;
    while (s_bri1 != 4'd8 && budget > 0) begin
      step();
      budget--;
    end
    check("duty_reach8", s_bri1, 8);
    step();
    count_s_led(hi);
    check("duty8", hi, exp_g8);
    budget = 200;
    while (s_bri1 != 4'd9 && budget > 0) begin
      step();
      budget--;
    end
    check("duty_reach9", s_bri1, 9);
    step();
    count_s_led(hi);
    check("duty9", hi, exp_g9);
    budget = 1000;
    while (s_bri1 != 4'd15 && budget > 0) begin
      step();
      budget--;
    end
    check("duty_reach15", s_bri1, 15);
    step();
    count_s_led(hi);
    check("duty15", hi, 16);
    check("slow_ch2", {s_bri2, s_led2, s_busy2}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
